pr_freelist_ctrl: RTL
=====================

PR_FREELIST_CTRL -- requirements
Module: pr_freelist_ctrl

Interface
REQ-001 SHALL have parameters: NUM_PR 64 (total physical registers); NUM_FREE 32 (free-list depth, NUM_PR minus 32 architectural registers).
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have ports: flush_stage4 in 1, pipeline flush; restores speculative state.
REQ-004 SHALL have ports: inst0..3_alloc_req in 1 each, rename slot k needs a destination PR.
REQ-005 SHALL have ports: inst0..3_alloc_PR out 6 each, PR assigned to slot k, valid only when that slot's request is granted.
REQ-006 SHALL have ports: alloc_stall out 1, requests in this cycle cannot all be served.
REQ-007 SHALL have ports: commit0..3_dest_en in 1 each, retiring instruction k wrote a destination register.
REQ-008 SHALL have ports: commit0..3_old_PR in 6 each, previous mapping freed by retiring instruction k.
REQ-009 SHALL have ports: free_cnt out 6, number of speculatively free PRs (0..32).

Function
REQ-010 SHALL hold a circular buffer of NUM_FREE 6-bit entries, with three 6-bit pointers: spec_head, commit_head and tail. Bit 5 of each pointer is the wrap bit; bits 4:0 are the index.
REQ-011 SHALL compute free_cnt = tail - spec_head (mod 64) and drive it combinationally from the registered pointers.
REQ-012 SHALL compute n_req as the popcount of the four alloc_req inputs.
REQ-013 SHALL assert alloc_stall when n_req > free_cnt OR flush_stage4 = 1, combinationally in the same cycle.
REQ-014 SHALL grant allocation all-or-nothing: when alloc_stall = 0, every requesting slot is granted; otherwise none is.
REQ-015 SHALL compact slot outputs: requesting slot k receives entry[spec_head + number of requesting slots below k]. Non-requesting slots output that same index value (don't-care).
REQ-016 SHALL drive alloc_PR outputs combinationally from the buffer within the request cycle, i.e. zero-cycle latency.
REQ-017 SHALL, on a granted cycle, set spec_head <= spec_head + n_req at the next edge.
REQ-018 SHALL, on commit, compute n_com = popcount of commit_dest_en. commit_old_PR values are written in slot order 0..3 (skipping disabled slots) at entry[tail], entry[tail+1], and so on. At the edge, tail <= tail + n_com and commit_head <= commit_head + n_com.
REQ-019 SHALL treat the commit_head advance as retiring the PRs allocated to the committing instructions; commit order equals allocation order.
REQ-020 SHALL not make PRs released in cycle T allocatable before cycle T+1. free_cnt in cycle T excludes them.
REQ-021 SHALL process allocation and commit in the same cycle independently; both pointer updates apply at one edge.
REQ-022 SHALL, on flush_stage4 = 1, set spec_head <= commit_head + n_com. Same-cycle commits are honoured: tail and commit_head also advance. Allocation is ignored.
REQ-023 SHALL wrap all pointer arithmetic modulo 64; index = pointer[4:0].
REQ-024 SHALL treat a commit that would make tail - commit_head exceed 32 as illegal. Behaviour is undefined and the bench flags it via assertion.
REQ-025 SHALL maintain the invariants commit_head <= spec_head <= tail (wrap-aware) and 0 <= free_cnt <= 32.

Reset
REQ-026 SHALL, on rst = 1 at a clk edge, set entry[i] <= 32+i for i = 0..31.
REQ-027 SHALL, on reset, set spec_head <= 0, commit_head <= 0 and tail <= 6'b100000, giving free_cnt = 32.
REQ-028 SHALL give rst priority over flush_stage4, allocation and commit.
REQ-029 SHALL, after reset with no requests, output alloc_stall = 0.

Verification
REQ-030 SHALL cover: reset, then all four slots request every cycle for 8 cycles -> PRs 32..63 issued in order; free_cnt 32,28,...,0; cycle 9 alloc_stall = 1.
REQ-031 SHALL cover: after reset, slots 1 and 3 request only -> inst1_alloc_PR = 32, inst3_alloc_PR = 33; next cycle free_cnt = 30.
REQ-032 SHALL cover: free_cnt = 0, commit with slots 0 and 2 enabled, old PR 5 and 9 -> free_cnt stays 0 that cycle; next cycle free_cnt = 2 and slot0 request gets 5.
REQ-033 SHALL cover: allocate 12 (3 cycles x4), commit 4, then flush -> spec_head = commit_head = 4 and free_cnt = 32, with tail advanced by 4.
REQ-034 SHALL cover: flush with 2 same-cycle commits and 4 requests -> requests not granted, alloc_stall = 1, spec_head = old commit_head + 2.
REQ-035 SHALL cover: sustained 4-allocate/4-commit for 20 cycles (pointer wrap) -> free_cnt constant, no PR duplicated among outstanding allocations (scoreboard check).

Source files
------------

// File: rtl/pr_freelist_ctrl_if.sv
// Rename free-list port bundle: four allocation slots, four commit slots, flush and status.
// The master side is the rename/retire pipeline; the slave side is the free-list controller.
interface pr_freelist_ctrl_if #(
  parameter int PR_W  = 6,
  parameter int CNT_W = 6
);
  logic             flush_stage4;

  logic             inst0_alloc_req;
  logic             inst1_alloc_req;
  logic             inst2_alloc_req;
  logic             inst3_alloc_req;
  logic [PR_W-1:0]  inst0_alloc_PR;
  logic [PR_W-1:0]  inst1_alloc_PR;
  logic [PR_W-1:0]  inst2_alloc_PR;
  logic [PR_W-1:0]  inst3_alloc_PR;
  logic             alloc_stall;

  logic             commit0_dest_en;
  logic             commit1_dest_en;
  logic             commit2_dest_en;
  logic             commit3_dest_en;
  logic [PR_W-1:0]  commit0_old_PR;
  logic [PR_W-1:0]  commit1_old_PR;
  logic [PR_W-1:0]  commit2_old_PR;
  logic [PR_W-1:0]  commit3_old_PR;

  logic [CNT_W-1:0] free_cnt;

  modport master (
    output flush_stage4,
    output inst0_alloc_req, inst1_alloc_req, inst2_alloc_req, inst3_alloc_req,
    input  inst0_alloc_PR, inst1_alloc_PR, inst2_alloc_PR, inst3_alloc_PR,
    input  alloc_stall,
    output commit0_dest_en, commit1_dest_en, commit2_dest_en, commit3_dest_en,
    output commit0_old_PR, commit1_old_PR, commit2_old_PR, commit3_old_PR,
    input  free_cnt
  );

  modport slave (
    input  flush_stage4,
    input  inst0_alloc_req, inst1_alloc_req, inst2_alloc_req, inst3_alloc_req,
    output inst0_alloc_PR, inst1_alloc_PR, inst2_alloc_PR, inst3_alloc_PR,
    output alloc_stall,
    input  commit0_dest_en, commit1_dest_en, commit2_dest_en, commit3_dest_en,
    input  commit0_old_PR, commit1_old_PR, commit2_old_PR, commit3_old_PR,
    output free_cnt
  );
endinterface

// File: rtl/pr_freelist_ctrl.sv
// Physical-register free list: 4-wide zero-latency allocation, 4-wide commit release, flush rollback.
// All-or-nothing grant; alloc_stall rises combinationally when requests exceed free entries or on flush.
module pr_freelist_ctrl #(
  parameter int NUM_PR   = 64,
  parameter int NUM_FREE = 32
) (
  input  logic             clk,
  input  logic             rst,
  pr_freelist_ctrl_if.slave fl
);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int IDX_W = $clog2(NUM_FREE);
  localparam int PTR_W = IDX_W + 1;

  logic [PR_W-1:0]  entry_q [NUM_FREE];
  logic [PTR_W-1:0] spec_head_q, spec_head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [3:0]       req;
  logic [3:0]       com_en;
  logic [PR_W-1:0]  old_pr   [4];
  logic [PR_W-1:0]  alloc_pr [4];
  logic [2:0]       req_off  [4];
  logic [2:0]       com_off  [4];
  logic [IDX_W-1:0] rd_idx   [4];
  logic [IDX_W-1:0] wr_idx   [4];
  logic [2:0]       n_req;
  logic [2:0]       n_com;
  logic [PTR_W-1:0] free_cnt;
  logic             alloc_stall;

  assign req    = {fl.inst3_alloc_req, fl.inst2_alloc_req, fl.inst1_alloc_req, fl.inst0_alloc_req};
  assign com_en = {fl.commit3_dest_en, fl.commit2_dest_en, fl.commit1_dest_en, fl.commit0_dest_en};

  assign old_pr[0] = fl.commit0_old_PR;
  assign old_pr[1] = fl.commit1_old_PR;
  assign old_pr[2] = fl.commit2_old_PR;
  assign old_pr[3] = fl.commit3_old_PR;

  // Exclusive prefix counts compact active slots onto consecutive buffer entries.
  always_comb begin
    req_off[0] = 3'd0;
    com_off[0] = 3'd0;
    for (int k = 1; k < 4; k++) begin
      req_off[k] = req_off[k-1] + {2'b00, req[k-1]};
      com_off[k] = com_off[k-1] + {2'b00, com_en[k-1]};
    end
  end

  assign n_req = req_off[3] + {2'b00, req[3]};
  assign n_com = com_off[3] + {2'b00, com_en[3]};

  // Uses registered pointers only, so same-cycle releases are not yet visible.
  assign free_cnt    = tail_q - spec_head_q;
  assign alloc_stall = (PTR_W'(n_req) > free_cnt) || fl.flush_stage4;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_idx[k]   = spec_head_q[IDX_W-1:0] + IDX_W'(req_off[k]);
      wr_idx[k]   = tail_q[IDX_W-1:0] + IDX_W'(com_off[k]);
      alloc_pr[k] = entry_q[rd_idx[k]];
    end
  end

  assign fl.inst0_alloc_PR = alloc_pr[0];
  assign fl.inst1_alloc_PR = alloc_pr[1];
  assign fl.inst2_alloc_PR = alloc_pr[2];
  assign fl.inst3_alloc_PR = alloc_pr[3];
  assign fl.alloc_stall    = alloc_stall;
  assign fl.free_cnt       = free_cnt;

  always_comb begin
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q + PTR_W'(n_com);
    tail_d        = tail_q + PTR_W'(n_com);
    // Flush rolls speculation back to the retired point, including this cycle's commits.
    if (fl.flush_stage4) begin
      spec_head_d = commit_head_q + PTR_W'(n_com);
    end else if (!alloc_stall) begin
      spec_head_d = spec_head_q + PTR_W'(n_req);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(NUM_FREE);
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FREE; i++) begin
        entry_q[i] <= PR_W'(NUM_PR - NUM_FREE + i);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (com_en[k]) begin
          entry_q[wr_idx[k]] <= old_pr[k];
        end
      end
    end
  end
endmodule
